mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels (2..8); channel 0 is the data cache, channel 1 the instruction cache.
REQ-002 Parameter ADDR_W, default 32: bus address width.
REQ-003 Parameter DATA_W, default 32: bus data width.
REQ-004 Parameter RR_MODE, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
REQ-005 Parameter TIMEOUT, default 255: maximum cycles to wait for gnt before an error completion; 0 disables the timeout.
REQ-006 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_i  in  1  asynchronous, active-low reset.
REQ-008 ch_req_i  in  NUM_CH  per-channel request level, held until that channel's ack or err.
REQ-009 ch_we_i  in  NUM_CH  per-channel write enable (1 = write, 0 = read).
REQ-010 ch_addr_i  in  NUM_CH*ADDR_W  per-channel address; channel k occupies slice [k*ADDR_W +: ADDR_W].
REQ-011 ch_wdata_i  in  NUM_CH*DATA_W  per-channel write data, sliced like ch_addr_i.
REQ-012 ch_ack_o  out  NUM_CH  one-cycle completion pulse to the owning channel.
REQ-013 ch_err_o  out  NUM_CH  one-cycle timeout-error pulse to the owning channel.
REQ-014 ch_rdata_o  out  DATA_W  registered read data, shared by all channels.
REQ-015 req_o, req_addr (ADDR_W), read_write (1), wdata (DATA_W)  out  bus request; read_write=1 means write.
REQ-016 rdata  in  DATA_W; gnt  in  1  bus read data and bus grant.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 In IDLE, when any ch_req_i bit is 1, the block SHALL select a winner, latch its index, we, addr and wdata, and enter BUSY on the next edge.
REQ-019 In fixed mode the winner SHALL be the lowest-indexed requesting channel.
REQ-020 In round-robin mode the winner SHALL be the first requesting channel at or after ptr, wrapping modulo NUM_CH; ptr SHALL become winner+1 (wrapping to 0 after NUM_CH-1) on each grant.
REQ-021 In BUSY the block SHALL drive req_o=1 with the latched addr, we and wdata, held stable until gnt.
REQ-022 In BUSY with gnt=1, the block SHALL register rdata into ch_rdata_o (reads only), deassert req_o and enter DONE.
REQ-023 In DONE the block SHALL pulse ch_ack_o[owner] for exactly one cycle, then return to IDLE; arbitration is not performed in DONE.
REQ-024 Latency: a request seen in IDLE at cycle 0 SHALL produce req_o at cycle 1; gnt at cycle k SHALL produce ack at cycle k+1; the minimum back-to-back spacing is 3 cycles.
REQ-025 A timeout counter SHALL load TIMEOUT on entry to BUSY and decrement each BUSY cycle without gnt; on reaching 0, the block SHALL go to DONE and pulse ch_err_o[owner] instead of ch_ack_o.
REQ-026 gnt in the same cycle that the counter reaches 0 SHALL count as success.
REQ-027 ch_rdata_o SHALL hold its value until the next successful read, and is unchanged by writes and timeouts.
REQ-028 gnt received outside BUSY SHALL be ignored.
REQ-029 Deassertion of the owner's ch_req_i mid-transaction SHALL NOT abort the transaction; ack/err still pulses.
REQ-030 ch_ack_o and ch_err_o SHALL be one-hot or zero, and never both set in the same cycle.

Reset
REQ-031 When rst_i=0, the block SHALL asynchronously force: state=IDLE, req_o=0, req_addr=0, read_write=0, wdata=0, ch_ack_o=0, ch_err_o=0, ch_rdata_o=0, ptr=0, counter=0.
REQ-032 Reset asserted mid-transaction SHALL drop req_o immediately and discard the transaction without ack or err.

Structure
REQ-033 State encodings and the On/Off constants SHALL come from the shared general-define include; the parameter defaults SHALL come from the shared riscv-spec configuration.
REQ-034 The winner selection SHALL be a sub-module, rr_pick (request vector, ptr, mode -> index, valid), which is purely combinational.

Verification
REQ-035 Fixed mode, ch_req_i=2'b11 in the same cycle, gnt after 2 cycles -> channel 0 acks first, then channel 1 is served.
REQ-036 RR mode, both channels requesting continuously for 4 transactions -> grant order 0,1,0,1.
REQ-037 Read of addr 0x100, gnt with rdata=0xDEADBEEF -> req_addr=0x100, read_write=0, ack pulses 1 cycle after gnt, ch_rdata_o=0xDEADBEEF.
REQ-038 Write with wdata=0x12345678 -> wdata and read_write=1 stable from req_o until gnt; ch_rdata_o unchanged.
REQ-039 TIMEOUT=4, gnt never asserted -> ch_err_o pulses for the owner, no ack, req_o drops, and the next request is served normally.
REQ-040 rst_i low during BUSY -> req_o=0 immediately, no ack or err, and state=IDLE after release.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared defaults, FSM encodings and on/off constants for the memory bus arbiter
package mem_bus_arbiter_pkg;
    localparam int NUM_CH_DEF  = 2;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam bit RR_MODE_DEF = 1'b0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester-channel and memory-bus signals seen by the arbiter
interface mem_bus_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_req, ch_we, ch_ack, ch_err;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [DATA_W-1:0]        ch_rdata, wdata, rdata;
    logic [ADDR_W-1:0]        req_addr;
    logic                     req, read_write, gnt;
    modport master (
        input  ch_req, ch_we, ch_addr, ch_wdata, rdata, gnt,
        output ch_ack, ch_err, ch_rdata, req, req_addr, read_write, wdata
    );
    modport slave (
        output ch_req, ch_we, ch_addr, ch_wdata, rdata, gnt,
        input  ch_ack, ch_err, ch_rdata, req, req_addr, read_write, wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// mem_bus_arbiter_rr_pick: combinational winner select, lowest index or first at/after ptr
module mem_bus_arbiter_rr_pick #(
    parameter int NUM_CH = 2,
    localparam int PW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    input  logic              mode,
    output logic [PW-1:0]     idx,
    output logic              valid
);
    int c;
    // scanning from the far end lets the first hit in search order win
    always_comb begin
        idx = '0;
        c = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = mode ? (k + int'(ptr)) % NUM_CH : k;
            if (req[c]) idx = PW'(c);
        end
    end
    assign valid = |req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates NUM_CH requesters onto one memory bus, with grant timeout
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit RR_MODE = RR_MODE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk_i,
    input logic rst_i,
    mem_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_CH);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [1:0]    state;
    logic [PW-1:0] owner, ptr, pick_idx;
    logic          pick_valid, expired;
    logic [CW-1:0] cnt;
    mem_bus_arbiter_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (bus.ch_req),
        .ptr   (ptr),
        .mode  (RR_MODE),
        .idx   (pick_idx),
        .valid (pick_valid)
    );
    // a zero TIMEOUT never expires; gnt on the expiry cycle still wins
    assign expired = (TIMEOUT != 0) && (cnt == '0);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= ST_IDLE;
            owner          <= '0;
            ptr            <= '0;
            cnt            <= '0;
            bus.req        <= OFF;
            bus.req_addr   <= '0;
            bus.read_write <= OFF;
            bus.wdata      <= '0;
            bus.ch_ack     <= '0;
            bus.ch_err     <= '0;
            bus.ch_rdata   <= '0;
        end else begin
            bus.ch_ack <= '0;
            bus.ch_err <= '0;
            if (state == ST_IDLE && pick_valid) begin
                state          <= ST_BUSY;
                owner          <= pick_idx;
                ptr            <= (int'(pick_idx) == NUM_CH - 1) ? '0 : pick_idx + 1'b1;
                cnt            <= CW'(TIMEOUT);
                bus.req        <= ON;
                bus.req_addr   <= bus.ch_addr[pick_idx*ADDR_W +: ADDR_W];
                bus.read_write <= bus.ch_we[pick_idx];
                bus.wdata      <= bus.ch_wdata[pick_idx*DATA_W +: DATA_W];
            end else if (state == ST_BUSY) begin
                if (bus.gnt || expired) begin
                    state             <= ST_DONE;
                    bus.req           <= OFF;
                    bus.ch_ack[owner] <= bus.gnt;
                    bus.ch_err[owner] <= !bus.gnt;
                    if (bus.gnt && !bus.read_write) bus.ch_rdata <= bus.rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule
